// File: rtl/periph_uart_rx.sv
// periph_uart_rx: configurable UART receiver delivering words on a valid/ready stream.
// Optional build macro UART_RX_SYNC_EN adds a 2-flop synchroniser on rx.
module periph_uart_rx #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  test,
    input  logic                  pause_req,
    output logic                  pause_ack,
    input  logic                  parity_select,
    input  logic                  parity_control,
    input  logic [3:0]            data_length,
    input  logic [1:0]            stop_bits,
    input  logic [DATA_WIDTH-1:0] baud_rate,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ready,
    input  logic                  rx
);

    localparam int unsigned MAX_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_PAUSED
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic [3:0]              bit_q, bit_d;
    logic [1:0]              stop_q, stop_d;
    logic [MAX_BITS-1:0]     shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    dv_q, dv_d;
    logic                    ack_q, ack_d;

    logic                    rx_in;
    logic                    tick_c;
    logic [3:0]              len_eff_c;
    logic [1:0]              stop_eff_c;
    logic                    last_data_c;
    logic                    last_stop_c;
    logic                    stop_err_c;
    logic                    unused_test;

    assign unused_test = test;

`ifdef UART_RX_SYNC_EN
    logic rx_s1_q, rx_s2_q;

    // Two-stage synchroniser for the asynchronous serial line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_in = rx_s2_q;
`else
    assign rx_in = rx;
`endif

    // Mid-bit sample strobe and frame-format decode
    assign tick_c      = (cnt_q <= DATA_WIDTH'(1));
    assign len_eff_c   = (data_length < 4'd5) ? 4'd5 :
                         (data_length > 4'd8) ? 4'd8 : data_length;
    assign stop_eff_c  = (stop_bits == 2'd0) ? 2'd1 : stop_bits;
    assign last_data_c = (bit_q == (len_eff_c - 4'd1));
    assign last_stop_c = (stop_q == (stop_eff_c - 2'd1));
    assign stop_err_c  = err_q | ~rx_in;

    // Next-state and output logic for the receive FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        err_d   = err_q;
        data_d  = data_q;
        // A consumed word frees the slot before any new frame is stored
        dv_d    = dv_q & ~data_ready;

        case (state_q)
            S_IDLE: begin
                if (pause_req) begin
                    state_d = S_PAUSED;
                end else if ((baud_rate != '0) && !rx_in) begin
                    cnt_d   = baud_rate >> 1;
                    bit_d   = 4'd0;
                    stop_d  = 2'd0;
                    shift_d = '0;
                    par_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (tick_c) begin
                    if (rx_in) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = baud_rate;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - DATA_WIDTH'(1);
                end
            end

            S_DATA: begin
                if (tick_c) begin
                    cnt_d                = baud_rate;
                    shift_d[bit_q[2:0]]  = rx_in;
                    par_d                = par_q ^ rx_in;
                    bit_d                = bit_q + 4'd1;
                    if (last_data_c) begin
                        state_d = parity_control ? S_PARITY : S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - DATA_WIDTH'(1);
                end
            end

            S_PARITY: begin
                if (tick_c) begin
                    cnt_d = baud_rate;
                    if (rx_in != (par_q ^ parity_select)) begin
                        err_d = 1'b1;
                    end
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - DATA_WIDTH'(1);
                end
            end

            S_STOP: begin
                if (tick_c) begin
                    cnt_d  = baud_rate;
                    stop_d = stop_q + 2'd1;
                    err_d  = stop_err_c;
                    if (last_stop_c) begin
                        state_d = S_IDLE;
                        if (!stop_err_c && !dv_d) begin
                            data_d = DATA_WIDTH'(shift_q);
                            dv_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - DATA_WIDTH'(1);
                end
            end

            S_PAUSED: begin
                if (!pause_req) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d = (state_d == S_PAUSED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            stop_q  <= 2'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            err_q   <= err_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ack_q   <= ack_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign pause_ack  = ack_q;

endmodule

// File: tb/tb_periph_uart_rx.sv
// tb_periph_uart_rx: directed bench for the UART receiver.
module tb_periph_uart_rx;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          test;
    logic          pause_req;
    logic          pause_ack;
    logic          parity_select;
    logic          parity_control;
    logic [3:0]    data_length;
    logic [1:0]    stop_bits;
    logic [DW-1:0] baud_rate;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          data_ready;
    logic          rx;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] rxq[$];

    always #10 clk = ~clk;

    periph_uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .test           (test),
        .pause_req      (pause_req),
        .pause_ack      (pause_ack),
        .parity_select  (parity_select),
        .parity_control (parity_control),
        .data_length    (data_length),
        .stop_bits      (stop_bits),
        .baud_rate      (baud_rate),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .rx             (rx)
    );

    // Record every word handed over on the output stream
    always @(negedge clk) begin
        if (rst && data_valid && data_ready) rxq.push_back(data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input bit par_en, input bit par_odd, input logic [3:0] len,
                           input logic [1:0] nstop, input int baud);
        parity_control = par_en;
        parity_select  = par_odd;
        data_length    = len;
        stop_bits      = nstop;
        baud_rate      = DW'(baud);
    endtask

    task automatic send_frame(input logic [7:0] val, input int len, input bit par_en,
                              input bit par_odd, input bit par_flip, input int nstop,
                              input bit stop_bad);
        int   b;
        logic p;
        b = int'(baud_rate);
        p = 1'b0;
        rx = 1'b0;
        tick(b);
        for (int i = 0; i < len; i++) begin
            rx = val[i];
            p  = p ^ val[i];
            tick(b);
        end
        if (par_en) begin
            rx = p ^ par_odd ^ par_flip;
            tick(b);
        end
        for (int i = 0; i < nstop; i++) begin
            rx = stop_bad ? 1'b0 : 1'b1;
            tick(b);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        checks++;
        if (data !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=%h", data, 32'h0);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", data_valid);
        end
        checks++;
        if (pause_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack got=%b exp=0", pause_ack);
        end
        rst = 1'b1;
        tick(3);
    endtask

    task automatic test_back_to_back();
        int n;
        set_cfg(1'b1, 1'b0, 4'd8, 2'd1, 8);
        data_ready = 1'b1;
        rxq.delete();
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 8, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        end
        tick(32);
        checks++;
        if (rxq.size() != 256) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=256", rxq.size());
        end
        n = (rxq.size() < 256) ? rxq.size() : 256;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (rxq[i] !== DW'(i)) begin
                errors++;
                $display("FAIL b2b_word[%0d] got=%h exp=%h", i, rxq[i], DW'(i));
            end
        end
    endtask

    task automatic test_odd_parity();
        int            n0;
        logic [DW-1:0] got;
        set_cfg(1'b1, 1'b1, 4'd8, 2'd1, 16);
        n0 = rxq.size();
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        tick(32);
        got = (rxq.size() > n0) ? rxq[n0] : 'x;
        checks++;
        if (got !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL odd_parity_word got=%h exp=%h", got, 32'h0000_00A5);
        end
        n0 = rxq.size();
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        tick(32);
        checks++;
        if (rxq.size() != n0) begin
            errors++;
            $display("FAIL parity_err_drop got=%0d words exp=0", rxq.size() - n0);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_err_valid got=%b exp=0", data_valid);
        end
    endtask

    task automatic test_len5_framing();
        int            n0;
        logic [DW-1:0] got;
        set_cfg(1'b0, 1'b0, 4'd5, 2'd1, 16);
        n0 = rxq.size();
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        got = (rxq.size() > n0) ? rxq[n0] : 'x;
        checks++;
        if (got !== 32'h0000_001F) begin
            errors++;
            $display("FAIL len5_word got=%h exp=%h", got, 32'h1F);
        end
        n0 = rxq.size();
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        tick(48);
        checks++;
        if (rxq.size() != n0) begin
            errors++;
            $display("FAIL framing_drop got=%0d words exp=0", rxq.size() - n0);
        end
        n0 = rxq.size();
        send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        got = (rxq.size() > n0) ? rxq[n0] : 'x;
        checks++;
        if (got !== 32'h0000_000A) begin
            errors++;
            $display("FAIL after_framing_word got=%h exp=%h", got, 32'h0A);
        end
    endtask

    task automatic test_overrun();
        int            n0;
        logic [DW-1:0] got;
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 16);
        data_ready = 1'b0;
        n0 = rxq.size();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_valid got=%b exp=1", data_valid);
        end
        checks++;
        if (data !== 32'h0000_0011) begin
            errors++;
            $display("FAIL overrun_held got=%h exp=%h", data, 32'h11);
        end
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_clear got=%b exp=0", data_valid);
        end
        got = (rxq.size() > n0) ? rxq[n0] : 'x;
        checks++;
        if (got !== 32'h0000_0011) begin
            errors++;
            $display("FAIL consume_word got=%h exp=%h", got, 32'h11);
        end
        tick(64);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_second_dropped got=%b exp=0", data_valid);
        end
        data_ready = 1'b1;
    endtask

    task automatic test_pause();
        int            n0;
        logic [DW-1:0] got;
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 16);
        data_ready = 1'b1;
        n0 = rxq.size();
        fork
            send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
            begin
                tick(48);
                pause_req = 1'b1;
            end
        join
        tick(32);
        got = (rxq.size() > n0) ? rxq[n0] : 'x;
        checks++;
        if (got !== 32'h0000_003C) begin
            errors++;
            $display("FAIL pause_inflight_word got=%h exp=%h", got, 32'h3C);
        end
        checks++;
        if (pause_ack !== 1'b1) begin
            errors++;
            $display("FAIL pause_ack_set got=%b exp=1", pause_ack);
        end
        n0 = rxq.size();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        checks++;
        if (rxq.size() != n0) begin
            errors++;
            $display("FAIL paused_ignored got=%0d words exp=0", rxq.size() - n0);
        end
        checks++;
        if (pause_ack !== 1'b1) begin
            errors++;
            $display("FAIL pause_ack_hold got=%b exp=1", pause_ack);
        end
        pause_req = 1'b0;
        tick(1);
        checks++;
        if (pause_ack !== 1'b0) begin
            errors++;
            $display("FAIL pause_ack_drop got=%b exp=0", pause_ack);
        end
        tick(4);
        n0 = rxq.size();
        send_frame(8'h66, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        got = (rxq.size() > n0) ? rxq[n0] : 'x;
        checks++;
        if (got !== 32'h0000_0066) begin
            errors++;
            $display("FAIL resume_word got=%h exp=%h", got, 32'h66);
        end
    endtask

    task automatic test_glitch_reset();
        int            n0;
        logic [DW-1:0] got;
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 434);
        data_ready = 1'b1;
        n0 = rxq.size();
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(600);
        checks++;
        if (rxq.size() != n0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL false_start got=%0d words valid=%b exp=0 words valid=0",
                     rxq.size() - n0, data_valid);
        end
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 16);
        data_ready = 1'b0;
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        checks++;
        if (data_valid !== 1'b1 || data !== 32'h77) begin
            errors++;
            $display("FAIL pre_reset_hold got=%b/%h exp=1/%h", data_valid, data, 32'h77);
        end
        rx = 1'b0;
        tick(48);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0 || data !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b/%h exp=0/%h", data_valid, data, 32'h0);
        end
        rx = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(160);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got=%b exp=0", data_valid);
        end
        data_ready = 1'b1;
        n0 = rxq.size();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(32);
        got = (rxq.size() > n0) ? rxq[n0] : 'x;
        checks++;
        if (got !== 32'h0000_005A) begin
            errors++;
            $display("FAIL post_reset_word got=%h exp=%h", got, 32'h5A);
        end
    endtask

    initial begin
        rst        = 1'b0;
        test       = 1'b0;
        pause_req  = 1'b0;
        data_ready = 1'b1;
        rx         = 1'b1;
        set_cfg(1'b1, 1'b0, 4'd8, 2'd1, 8);
        test_reset();
        test_back_to_back();
        test_odd_parity();
        test_len5_framing();
        test_overrun();
        test_pause();
        test_glitch_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
